// File: rtl/lcd_frame_reader.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_reader
// Purpose  : Avalon-MM read master that streams a linear block of 32-bit pixel
//            words through a show-ahead FIFO to a valid/ready sink.
//            Optional macro LCD_FRAME_READER_IRQ_EN adds irq/underrun_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_reader #(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [31:0]       st_data,
    output logic              st_valid,
    input  logic              st_ready
`ifdef LCD_FRAME_READER_IRQ_EN
    ,
    output logic              irq,
    input  logic              irq_clear,
    output logic [15:0]       underrun_cnt
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W:0]   DEPTH_EXT = (OCC_W + 1)'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0] FULL_CNT  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [OCC_W-1:0]  outstanding_q, outstanding_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic              done_q, done_d;
    logic              stall_q;
    logic [31:0]       mem_q [FIFO_DEPTH];

    logic              read_ok;
    logic              accept;
    logic              rdv;
    logic              push;
    logic              pop;
    logic              abort_go;
    logic [OCC_W:0]    in_use;

    // Reads in flight plus buffered words bound the issue window so the FIFO never overflows.
    assign in_use      = {1'b0, outstanding_q} + {1'b0, count_q};
    assign read_ok     = (state_q == S_READ) && (remaining_q != '0) && (in_use < DEPTH_EXT);
    assign avm_read    = read_ok || ((state_q == S_ABORT) && stall_q);
    assign avm_address = addr_q;
    assign accept      = avm_read && !avm_waitrequest;
    assign rdv         = avm_readdatavalid && (outstanding_q != '0);
    assign abort_go    = abort && ((state_q == S_READ) || (state_q == S_DRAIN));
    assign push        = rdv && !abort_go && ((state_q == S_READ) || (state_q == S_DRAIN));
    assign st_valid    = (count_q != '0);
    assign st_data     = st_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign pop         = st_valid && st_ready;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        done_d        = 1'b0;
        outstanding_d = outstanding_q + OCC_W'(accept) - OCC_W'(rdv);
        count_d       = count_q + OCC_W'(push) - OCC_W'(pop);
        rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d      = wr_ptr_q + PTR_W'(push);

        if (accept) begin
            addr_d      = addr_q + ADDR_W'(4);
            remaining_d = remaining_q - CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = S_READ;
                        addr_d      = {base_addr[ADDR_W-1:2], 2'b00};
                        remaining_d = word_count;
                    end
                end
            end
            S_READ: begin
                if (abort)
                    state_d = S_ABORT;
                else if (remaining_d == '0)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort) begin
                    state_d = S_ABORT;
                end else if ((outstanding_q == '0) && (count_q == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_ABORT: begin
                // A stalled request must be accepted before we can retire.
                if ((outstanding_q == '0) && !avm_read) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort_go) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            addr_q        <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            done_q        <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            remaining_q   <= remaining_d;
            outstanding_q <= outstanding_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            done_q        <= done_d;
            stall_q       <= avm_read && avm_waitrequest;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= avm_readdata;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == FULL_CNT)));

`ifdef LCD_FRAME_READER_IRQ_EN
    logic        irq_q;
    logic [15:0] underrun_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q      <= 1'b0;
            underrun_q <= 16'd0;
        end else begin
            if (done_d)
                irq_q <= 1'b1;
            else if (irq_clear)
                irq_q <= 1'b0;

            if ((state_q == S_IDLE) && start)
                underrun_q <= 16'd0;
            else if (((state_q == S_READ) || (state_q == S_DRAIN)) && !st_valid &&
                     st_ready && (underrun_q != 16'hFFFF))
                underrun_q <= underrun_q + 16'd1;
        end
    end

    assign irq          = irq_q;
    assign underrun_cnt = underrun_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_reader.sv
`default_nettype none
// Testbench for lcd_frame_reader: randomized Avalon slave and stream sink,
// checked against a queue-based model of the expected address/word sequence.
module tb_lcd_frame_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        busy, done;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] st_data;
    logic        st_valid;
    logic        st_ready = 1'b1;

    lcd_frame_reader #(.ADDR_W(32), .CNT_W(16), .FIFO_DEPTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .base_addr(base_addr), .word_count(word_count),
        .busy(busy), .done(done),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Environment knobs
    bit          wait_rand  = 1'b0;
    int          ready_mode = 0;     // 0: always ready, 1: never ready, 2: random
    int          lat_extra  = 0;
    logic [31:0] mem_base   = '0;
    logic [31:0] mem_key    = '0;

    // Observation logs
    logic [31:0] acc_addr[$];
    logic [31:0] got[$];
    int          acc_cnt, rdv_cnt, done_cnt, stall_err, done_bal_err;
    bit          prev_stall;
    logic [31:0] prev_addr;
    bit          acc_n;
    logic [31:0] addr_n;

    // Slave memory contents: word k of the block holds key + k.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return mem_key + ((a - mem_base) >> 2);
    endfunction

    // Random handshake drivers
    always @(posedge clk) begin
        #2;
        avm_waitrequest = wait_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        st_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    // Avalon slave: in-order responses, latency 1 + lat_extra cycles
    logic [31:0] resp_data[$];
    int          resp_due[$];
    int          cyc = 0;
    always @(posedge clk) begin
        cyc++;
        #1;
        if (reset) begin
            resp_data.delete();
            resp_due.delete();
            avm_readdatavalid = 1'b0;
        end else begin
            if (acc_n) begin
                resp_data.push_back(memf(addr_n));
                resp_due.push_back(cyc + lat_extra);
            end
            if ((resp_due.size() > 0) && (resp_due[0] <= cyc)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = resp_data.pop_front();
                void'(resp_due.pop_front());
            end else begin
                avm_readdatavalid = 1'b0;
                avm_readdata      = $urandom;
            end
        end
    end

    // Bus and stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            acc_n      = 1'b0;
            prev_stall = 1'b0;
        end else begin
            acc_n  = avm_read && !avm_waitrequest;
            addr_n = avm_address;
            if (acc_n) begin
                acc_addr.push_back(avm_address);
                acc_cnt++;
            end
            if (avm_readdatavalid) rdv_cnt++;
            if (st_valid && st_ready) got.push_back(st_data);
            if (done) begin
                done_cnt++;
                if (rdv_cnt != acc_cnt) done_bal_err++;
            end
            if (prev_stall && !(avm_read && (avm_address == prev_addr))) stall_err++;
            prev_stall = avm_read && avm_waitrequest;
            prev_addr  = avm_address;
        end
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic clear_logs();
        acc_addr.delete();
        got.delete();
        acc_cnt = 0; rdv_cnt = 0; done_cnt = 0; stall_err = 0; done_bal_err = 0;
    endtask

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        tick();
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        while (!ok && (n < budget)) begin
            tick();
            n++;
            if (done_cnt != 0) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (avm_read !== 1'b0) $display("FAIL reset_read: got %b want 0", avm_read); else passed++;
        total++; if (avm_address !== 32'd0) $display("FAIL reset_addr: got %h want 0", avm_address); else passed++;
        total++; if (st_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", st_valid); else passed++;
        total++; if (st_data !== 32'd0) $display("FAIL reset_data: got %h want 0", st_data); else passed++;
        reset = 1'b0;
        repeat (2) tick();
        total++; if (busy !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy); else passed++;
    endtask

    // Compares the logged addresses and words against the model for n words.
    task automatic test_stream_result(input string name, input int n);
        logic [31:0] a, d;
        total++;
        if (acc_cnt !== n) $display("FAIL %s_read_count: got %0d want %0d", name, acc_cnt, n); else passed++;
        for (int i = 0; i < n; i++) begin
            a = (i < acc_addr.size()) ? acc_addr[i] : 32'hxxxxxxxx;
            total++;
            if (a !== mem_base + 32'(4 * i))
                $display("FAIL %s_addr[%0d]: got %h want %h", name, i, a, mem_base + 32'(4 * i));
            else passed++;
        end
        total++;
        if (got.size() !== n) $display("FAIL %s_word_count: got %0d want %0d", name, got.size(), n); else passed++;
        for (int i = 0; i < n; i++) begin
            d = (i < got.size()) ? got[i] : 32'hxxxxxxxx;
            total++;
            if (d !== mem_key + 32'(i)) $display("FAIL %s_data[%0d]: got %h want %h", name, i, d, mem_key + 32'(i));
            else passed++;
        end
    endtask

    task automatic test_basic();
        bit ok; int n;
        clear_logs();
        mem_base = 32'h100; mem_key = 32'hA000_0000;
        pulse_start(32'h100, 16'd8);
        total++; if (avm_read !== 1'b1) $display("FAIL basic_first_read: got %b want 1", avm_read); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
        wait_done(200, ok, n);
        total++; if (!ok) $display("FAIL basic_done_timeout: got no done want done"); else passed++;
        total++; if (n > 14) $display("FAIL basic_throughput: got %0d cycles want <=14", n); else passed++;
        repeat (4) tick();
        test_stream_result("basic", 8);
        total++; if (done_cnt !== 1) $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else passed++;
    endtask

    task automatic test_zero_count();
        clear_logs();
        pulse_start($urandom, 16'd0);
        total++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else passed++;
        tick();
        total++; if (done !== 1'b0) $display("FAIL zero_done_width: got %b want 0", done); else passed++;
        repeat (5) tick();
        total++; if (acc_cnt !== 0) $display("FAIL zero_reads: got %0d want 0", acc_cnt); else passed++;
        total++; if (done_cnt !== 1) $display("FAIL zero_done_pulses: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        bit ok; int n;
        clear_logs();
        mem_base = $urandom & 32'h00FF_FFFC; mem_key = $urandom;
        ready_mode = 1;
        pulse_start(mem_base, 16'd40);
        repeat (50) tick();
        total++; if (acc_cnt !== 16) $display("FAIL bp_reads_window: got %0d want 16", acc_cnt); else passed++;
        total++; if (avm_read !== 1'b0) $display("FAIL bp_read_held: got %b want 0", avm_read); else passed++;
        total++; if (st_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", st_valid); else passed++;
        ready_mode = 0;
        wait_done(400, ok, n);
        total++; if (!ok) $display("FAIL bp_done_timeout: got no done want done"); else passed++;
        repeat (3) tick();
        test_stream_result("bp", 40);
        total++; if (done_cnt !== 1) $display("FAIL bp_done_pulses: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_random_wait();
        bit ok; int n;
        logic [31:0] b;
        clear_logs();
        b = $urandom;
        mem_base = b & 32'hFFFF_FFFC; mem_key = $urandom;
        wait_rand = 1'b1; ready_mode = 2;
        pulse_start(b, 16'd40);
        wait_done(3000, ok, n);
        total++; if (!ok) $display("FAIL rw_done_timeout: got no done want done"); else passed++;
        wait_rand = 1'b0; ready_mode = 0;
        repeat (3) tick();
        total++; if (stall_err !== 0) $display("FAIL rw_stall_stability: got %0d violations want 0", stall_err); else passed++;
        test_stream_result("rw", 40);
        total++; if (done_cnt !== 1) $display("FAIL rw_done_pulses: got %0d want 1", done_cnt); else passed++;
    endtask

    task automatic test_abort();
        bit ok, hit; int n, got_at;
        logic [31:0] d;
        clear_logs();
        mem_base = $urandom & 32'h00FF_FFFC; mem_key = $urandom;
        lat_extra = 1;
        pulse_start(mem_base, 16'd20);
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if ((acc_cnt == 4) && avm_read && !avm_waitrequest) begin
                abort = 1'b1;
                hit   = 1'b1;
            end else tick();
        end
        total++; if (!hit) $display("FAIL abort_trigger: got no 5th read want 5th read"); else passed++;
        tick();
        abort = 1'b0;
        total++; if (st_valid !== 1'b0) $display("FAIL abort_valid: got %b want 0", st_valid); else passed++;
        total++; if (avm_read !== 1'b0) $display("FAIL abort_read: got %b want 0", avm_read); else passed++;
        total++; if (acc_cnt - rdv_cnt !== 2) $display("FAIL abort_outstanding: got %0d want 2", acc_cnt - rdv_cnt); else passed++;
        got_at = got.size();
        wait_done(100, ok, n);
        total++; if (!ok) $display("FAIL abort_done_timeout: got no done want done"); else passed++;
        repeat (5) tick();
        total++; if (acc_cnt !== 5) $display("FAIL abort_reads: got %0d want 5", acc_cnt); else passed++;
        total++; if (got.size() !== got_at) $display("FAIL abort_discard: got %0d words want %0d", got.size(), got_at); else passed++;
        for (int i = 0; i < got.size(); i++) begin
            d = got[i];
            total++;
            if (d !== mem_key + 32'(i)) $display("FAIL abort_data[%0d]: got %h want %h", i, d, mem_key + 32'(i));
            else passed++;
        end
        total++; if (done_cnt !== 1) $display("FAIL abort_done_pulses: got %0d want 1", done_cnt); else passed++;
        total++; if (done_bal_err !== 0) $display("FAIL abort_done_early: got %0d want 0", done_bal_err); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else passed++;
        lat_extra = 0;
    endtask

    task automatic test_back_to_back();
        bit ok; int n;
        clear_logs();
        mem_base = 32'hFFFF_FFF8; mem_key = $urandom;
        pulse_start(32'hFFFF_FFF8, 16'd4);
        pulse_start(32'h0000_0040, 16'd9);
        wait_done(200, ok, n);
        total++; if (!ok) $display("FAIL b2b_done_timeout: got no done want done"); else passed++;
        repeat (8) tick();
        test_stream_result("wrap", 4);
        total++; if (done_cnt !== 1) $display("FAIL wrap_done_pulses: got %0d want 1", done_cnt); else passed++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        clear_logs();
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_random_wait();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/lcd_frame_reader.md
Name: lcd_frame_reader

Overview:
- Avalon-MM read master that fetches a linear block of 32-bit pixel words from on-chip memory (an Avalon-MM slave with read latency 1) and streams them to the LCD output path.
- Pipelines reads up to FIFO capacity and buffers the returned data in an internal FIFO.
- Data leaves through a valid/ready stream.
- Sits between the on-chip frame memory and the LCD pixel serializer.

Parameters:
- ADDR_W, 32, byte-address width of avm_address.
- CNT_W, 16, width of word_count.
- FIFO_DEPTH, 16, internal FIFO depth in words; must be a power of two, ≥4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; latches base_addr/word_count when idle.
- abort  in  1  one-cycle pulse; cancels the transfer in progress.
- base_addr  in  ADDR_W  byte start address; bits [1:0] ignored (treated as 0).
- word_count  in  CNT_W  number of 32-bit words to fetch.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at transfer end (normal or aborted).
- avm_address  out  ADDR_W  byte address, word-aligned.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data qualifier.
- st_data  out  32  pixel word.
- st_valid  out  1  st_data valid.
- st_ready  in  1  sink accepts st_data.

Behaviour:
- Reset: busy=0, done=0, avm_read=0, avm_address=0, st_valid=0, st_data=0. FIFO is empty, and all counters and the outstanding count are 0. Reset mid-transfer drops everything, and later readdatavalid pulses are ignored because the outstanding count is 0.
- States:
  - IDLE: start → if word_count==0, pulse done next cycle and stay IDLE; else go to READ, busy=1, addr=base_addr&~3, remaining=word_count. start while busy is ignored.
  - READ: assert avm_read when remaining>0 and outstanding+fifo_count<FIFO_DEPTH. A request is accepted on a cycle with avm_read=1 and avm_waitrequest=0; then addr+=4 (wraps modulo 2^ADDR_W), remaining-=1, outstanding+=1. When remaining hits 0, go to DRAIN.
  - DRAIN: wait until outstanding==0 and FIFO empty (last word accepted by sink). Then pulse done, busy=0, go to IDLE.
  - ABORTING: entered from READ/DRAIN on abort. avm_read deasserts next cycle unless waitrequest is held; an in-flight stalled request stays asserted with a stable address until accepted. The FIFO is flushed immediately and st_valid=0. Returning data for outstanding reads is discarded. When outstanding==0, pulse done and go to IDLE. abort in IDLE is ignored.
- Avalon rules: avm_address and avm_read must stay stable while avm_waitrequest=1. No byteenable and no writes are issued.
- Outstanding counter: +1 on accepted request, -1 on readdatavalid. When both happen in the same cycle the net change is 0.
- FIFO:
  - Show-ahead: st_valid=!empty and st_data=head. Push happens on readdatavalid (not in ABORTING); pop happens on st_valid&st_ready.
  - Simultaneous push and pop keeps the count unchanged. Push when full cannot occur because of the issue rule; an assertion flags it.
- Throughput: 1 word/cycle sustained when waitrequest=0 and st_ready=1.
- Latency: first avm_read in the cycle after start; first st_valid the cycle after the first readdatavalid.

Optional Feature:
- Macro LCD_FRAME_READER_IRQ_EN.
- When defined, the block adds:
  - Port irq (out 1): set on done, cleared by irq_clear (in 1). Set has priority when both occur in the same cycle. Reset value 0.
  - Port underrun_cnt (out 16): counts cycles in READ/DRAIN with FIFO empty while st_ready=1. Saturates at 0xFFFF and clears on start.
- When undefined, these ports and their logic are absent.

Test Plan:
- base_addr=0x100, word_count=8, waitrequest=0, st_ready=1, memory word i = 0xA000_0000+i → reads at 0x100..0x11C; st_data 0xA0000000..0xA0000007 in order; done pulses once after the 8th pop; busy 1→0.
- word_count=0 → no avm_read; done pulses 1 cycle after start; busy stays 0.
- FIFO_DEPTH=16, word_count=40, st_ready=0 for 50 cycles → exactly 16 reads issued, then avm_read=0. After st_ready=1, all 40 words are delivered in order.
- Random waitrequest (50%) → address and read are stable through each stall; 40 words delivered, none duplicated or skipped.
- abort after 5 accepted reads with 2 outstanding → st_valid=0 next cycle; the 2 returns are discarded; done pulses once outstanding==0; no further reads.
- base_addr=0xFFFF_FFF8, word_count=4 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; start pulsed while busy is ignored.
